// File: rtl/regfile_sb.sv
// Parametrised register file with write-through bypass and a per-register
// pending-writeback scoreboard feeding the decode-stage hazard logic.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic                       iss_waw,
  output logic [ADDR_W:0]            pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;
  logic              iss_ok;
  logic              inc;
  logic              dec;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_ok  = wr_en && !is_zero(wr_addr);
  assign iss_ok = iss_en && !is_zero(iss_addr);

  // Count delta mirrors the busy update: a same-address issue overrides the clear.
  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    if (iss_ok && wr_ok && (iss_addr == wr_addr)) begin
      inc = !busy[iss_addr];
    end else begin
      inc = iss_ok && !busy[iss_addr];
      dec = wr_ok && busy[wr_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr]  <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      if (iss_ok) busy[iss_addr] <= 1'b1;
      pend_cnt <= pend_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    end
  end

  assign iss_waw = iss_ok && busy[iss_addr] && !(wr_ok && (wr_addr == iss_addr));

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              z;
    logic              hit;
    assign a   = rd_addr[i*ADDR_W +: ADDR_W];
    assign z   = is_zero(a);
    assign hit = wr_ok && (wr_addr == a);
    assign rd_data[i*DATA_W +: DATA_W] = z ? '0 : (hit ? wr_data : mem[a]);
    assign rd_busy[i] = !z && busy[a] && !hit;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file for the pipelined MIPS32 datapath, replacing the fixed 32x32, two-read-port register bank.
- Configurable data width, register count and number of read ports.
- Register 0 is hardwired to zero, and a same-cycle write is forwarded straight to the read ports (write-through bypass).
- A per-register scoreboard tracks pending writebacks so the hazard unit can stall the decode stage.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- NUM_RD, 2, number of independent read ports.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and issues; when 0 it is an ordinary register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data for port i, combinational.
- rd_busy  out  NUM_RD  bit i high when the register at rd_addr(i) has a pending writeback.
- wr_en  in  1  writeback enable.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  an instruction with a destination register issues this cycle.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- iss_waw  out  1  issuing to a register that is still busy (WAW hazard indication).
- pend_cnt  out  ADDR_W+1  registered count of busy registers.

Behaviour:
- Reset:
  - Single-cycle synchronous reset; rst=1 at a rising edge clears every register to 0, every busy bit to 0 and pend_cnt to 0.
  - rst has priority over wr_en and iss_en in the same cycle.
  - After that edge, rd_data = 0, rd_busy = 0 and iss_waw = 0 for all ports.
  - Reset asserted mid-operation discards any pending state, with no partial write.
- Zero register (ZERO_REG=1): a write or issue to address 0 has no effect on storage or busy bits. A read of address 0 returns 0 with rd_busy=0, including under bypass.
- Write:
  - On a rising edge with wr_en=1 and rst=0, reg[wr_addr] <= wr_data.
  - The write is visible on a combinational read in the following cycle.
- Read (combinational, no latency):
  - Default: rd_data(i) = reg[rd_addr(i)].
  - Bypass: if wr_en=1 and wr_addr==rd_addr(i) (and not the zero register), rd_data(i) = wr_data in the same cycle.
  - Multiple ports reading the same address return identical data.
- Scoreboard:
  - busy[] holds 2**ADDR_W bits, updated on the rising edge.
  - iss_en sets busy[iss_addr]; wr_en clears busy[wr_addr].
  - Issue and writeback to the same address in the same cycle: the set wins, because a new producer has issued and busy stays 1.
  - Issue and writeback to different addresses in the same cycle: both take effect.
  - rd_busy(i) = busy[rd_addr(i)] AND NOT (wr_en AND wr_addr==rd_addr(i)). The bypass satisfies the dependency in the writeback cycle.
- iss_waw:
  - Combinational: iss_en AND busy[iss_addr] AND NOT (wr_en AND wr_addr==iss_addr).
  - Always 0 for address 0 when ZERO_REG=1.
  - Informational only; the issue still sets the bit.
- pend_cnt:
  - Always equals popcount(busy) after each edge.
  - Changes by +1, -1 or 0 per cycle.
  - Range 0..2**ADDR_W; it cannot overflow because it is ADDR_W+1 bits wide.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- There are no X sources: the storage array is fully cleared by rst, and no initial-block dependence is allowed.

Test Plan:
- Reset then read: assert rst for 1 cycle, then read r0..r31 on both ports -> all rd_data=0x00000000, rd_busy=0, pend_cnt=0.
- Write/read and zero register:
  - Write r5=0xDEADBEEF, next cycle read port0=r5 -> 0xDEADBEEF.
  - Write r0=0x12345678, read r0 -> 0x00000000.
- Bypass: in one cycle wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr port1=7, with r7 previously 0x1 -> rd_data port1=0xA5A5A5A5 in the same cycle, 0xA5A5A5A5 from storage the next cycle.
- Scoreboard lifecycle:
  - Issue r3 -> next cycle rd_busy=1 and pend_cnt=1.
  - Writeback r3 -> same cycle rd_busy=0; next cycle pend_cnt=0.
- Simultaneous and WAW cases:
  - With r9 busy, issue r9 and writeback r9 in the same cycle -> iss_waw=0, busy stays 1, pend_cnt unchanged.
  - Issue r9 again without writeback -> iss_waw=1.
  - Issue r0 -> pend_cnt unchanged.
- Reset mid-operation: issue r1, r2 and r4, write r1=0x55, then rst=1 together with wr_en=1 and iss_en=1 -> pend_cnt=0, all busy=0, r1 reads 0, and neither the write nor the issue takes effect.
